// File: rtl/disp_cmd_pkg.sv
// -----------------------------------------------------------------------------
// disp_cmd_pkg
//   Shared definitions for the display command FIFO path.
//   - wr_state_t      : producer write state encoding (2 bits)
//   - FIFO_FULL       : level of the active-low FIFO full flag when full
//   - STROBE_ACTIVE   : level of the active-low FIFO write strobe when asserted
//   - CMD_W           : command byte width
//   - phase_done()    : true on the last tick of a timed phase
// -----------------------------------------------------------------------------
package disp_cmd_pkg;

    localparam int   CMD_W         = 8;
    localparam logic FIFO_FULL     = 1'b0;
    localparam logic STROBE_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_SETUP = 2'd1,
        WR_PULSE = 2'd2,
        WR_HOLD  = 2'd3
    } wr_state_t;

    // A phase of length len occupies ticks 0 .. len-1; the last one ends it.
    function automatic logic phase_done(input logic [7:0] tick, input logic [7:0] len);
        return (tick == (len - 8'd1));
    endfunction

endpackage

// File: rtl/cmd_fifo_writer.sv
// -----------------------------------------------------------------------------
// cmd_fifo_writer
//   Producer-side state machine for the display command FIFO. Pulls one byte
//   at a time from the shared command register and writes it into an external
//   asynchronous FIFO, timing the active-low write strobe in system clocks:
//   SETUP_TICKS with data valid and strobe high, PULSE_TICKS with the strobe
//   low, HOLD_TICKS with data held after the strobe rises.
//
//   Optional feature: define CMD_FIFO_WRITER_COUNT_EN to add the wr_count
//   port and its 16-bit completed-write counter.
//
// Parameters (each must be at least 1, at most 256):
//   SETUP_TICKS  clocks of data setup before the strobe falls
//   PULSE_TICKS  clocks the strobe is held low
//   HOLD_TICKS   clocks of data hold after the strobe rises
//
// Ports:
//   clk                in   system clock, rising edge
//   rst                in   asynchronous active-high reset
//   nff                in   FIFO full flag, active low (0 = full)
//   disp_cmd_wr        out  FIFO write strobe, active low
//   disp_cmd_out[7:0]  out  data to FIFO input bus
//   cmdreg_data_avail  in   shared register holds a byte
//   cmdreg_data[7:0]   in   shared register contents
//   cmdreg_rd          out  one-cycle consume strobe to shared register
//   wr_count[15:0]     out  completed writes (CMD_FIFO_WRITER_COUNT_EN only)
//
// All outputs are registered; no combinational input-to-output path exists.
// -----------------------------------------------------------------------------
import disp_cmd_pkg::*;

module cmd_fifo_writer #(
    parameter int SETUP_TICKS = 1,
    parameter int PULSE_TICKS = 3,
    parameter int HOLD_TICKS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nff,
    output logic             disp_cmd_wr,
    output logic [CMD_W-1:0] disp_cmd_out,
    input  logic             cmdreg_data_avail,
    input  logic [CMD_W-1:0] cmdreg_data,
    output logic             cmdreg_rd
`ifdef CMD_FIFO_WRITER_COUNT_EN
    ,
    output logic [15:0]      wr_count
`endif
);

    localparam logic [7:0] SETUP_LEN = 8'(SETUP_TICKS);
    localparam logic [7:0] PULSE_LEN = 8'(PULSE_TICKS);
    localparam logic [7:0] HOLD_LEN  = 8'(HOLD_TICKS);

    wr_state_t  state_r;
    logic [7:0] tick_r;

    // Write FSM, phase tick counter and all output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= WR_IDLE;
            tick_r       <= 8'd0;
            disp_cmd_wr  <= ~STROBE_ACTIVE;
            disp_cmd_out <= {CMD_W{1'b0}};
            cmdreg_rd    <= 1'b0;
`ifdef CMD_FIFO_WRITER_COUNT_EN
            wr_count     <= 16'd0;
`endif
        end else begin
            // The consume strobe is only ever high for the cycle after accept.
            cmdreg_rd <= 1'b0;

            case (state_r)
                WR_IDLE: begin
                    // Full flag is only looked at here; once a byte is
                    // accepted the write always runs to completion.
                    if (cmdreg_data_avail && (nff != FIFO_FULL)) begin
                        disp_cmd_out <= cmdreg_data;
                        cmdreg_rd    <= 1'b1;
                        tick_r       <= 8'd0;
                        state_r      <= WR_SETUP;
                    end else begin
                        tick_r       <= 8'd0;
                        state_r      <= WR_IDLE;
                    end
                end

                WR_SETUP: begin
                    if (phase_done(tick_r, SETUP_LEN)) begin
                        disp_cmd_wr <= STROBE_ACTIVE;
                        tick_r      <= 8'd0;
                        state_r     <= WR_PULSE;
                    end else begin
                        tick_r      <= tick_r + 8'd1;
                    end
                end

                WR_PULSE: begin
                    if (phase_done(tick_r, PULSE_LEN)) begin
                        // FIFO latches disp_cmd_out on this rising edge.
                        disp_cmd_wr <= ~STROBE_ACTIVE;
`ifdef CMD_FIFO_WRITER_COUNT_EN
                        wr_count    <= wr_count + 16'd1;
`endif
                        tick_r      <= 8'd0;
                        state_r     <= WR_HOLD;
                    end else begin
                        tick_r      <= tick_r + 8'd1;
                    end
                end

                WR_HOLD: begin
                    if (phase_done(tick_r, HOLD_LEN)) begin
                        tick_r  <= 8'd0;
                        state_r <= WR_IDLE;
                    end else begin
                        tick_r  <= tick_r + 8'd1;
                    end
                end

                default: begin
                    // Unreachable with a 2-bit, fully enumerated state; fall
                    // back to a safe idle with the strobe released.
                    disp_cmd_wr <= ~STROBE_ACTIVE;
                    tick_r      <= 8'd0;
                    state_r     <= WR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_fifo_writer.sv
module tb_cmd_fifo_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nff = 1'b1;
    logic       disp_cmd_wr;
    logic [7:0] disp_cmd_out;
    logic       cmdreg_data_avail = 1'b0;
    logic [7:0] cmdreg_data = 8'h00;
    logic       cmdreg_rd;
`ifdef CMD_FIFO_WRITER_COUNT_EN
    logic [15:0] wr_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int captured     = 0;
    int rd_seen      = 0;
    int low_cycles   = 0;
    logic [7:0] exp_q[$];

    cmd_fifo_writer dut (
        .clk               (clk),
        .rst               (rst),
        .nff               (nff),
        .disp_cmd_wr       (disp_cmd_wr),
        .disp_cmd_out      (disp_cmd_out),
        .cmdreg_data_avail (cmdreg_data_avail),
        .cmdreg_data       (cmdreg_data),
        .cmdreg_rd         (cmdreg_rd)
`ifdef CMD_FIFO_WRITER_COUNT_EN
        ,
        .wr_count          (wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: latches on the strobe's rising edge (ignored while in reset)
    always @(posedge disp_cmd_wr) begin
        if (rst !== 1'b1) begin
            captured++;
            check("strobe_low_cycles", low_cycles, 3);
            if (exp_q.size() == 0) begin
                check("unexpected_fifo_write", {24'd0, disp_cmd_out}, 32'hFFFF_FFFF);
            end else begin
                check("fifo_data", {24'd0, disp_cmd_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge disp_cmd_wr) low_cycles = 0;
    always @(posedge clk) if (disp_cmd_wr === 1'b0) low_cycles++;
    always @(negedge clk) if (cmdreg_rd === 1'b1) rd_seen++;

    // Wait (bounded) for the consume strobe; returns cycles waited.
    task automatic wait_rd(input string name, output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cmdreg_rd === 1'b1) begin
                cycles = i;
                return;
            end
        end
        check({name, "_rd_timeout"}, 32'd0, 32'd1);
    endtask

    int n;
    int rd_cnt;
    logic exp_wr[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_rd[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        // Reset held with a byte available
        cmdreg_data = 8'h5A;
        cmdreg_data_avail = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_wr", disp_cmd_wr, 1'b1);
            check("rst_rd", cmdreg_rd, 1'b0);
            check("rst_out", disp_cmd_out, 8'h00);
`ifdef CMD_FIFO_WRITER_COUNT_EN
            check("rst_count", wr_count, 16'd0);
`endif
        end
        cmdreg_data_avail = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single write A5, cycle-exact strobe timing
        cmdreg_data = 8'hA5;
        cmdreg_data_avail = 1'b1;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) cmdreg_data_avail = 1'b0;
            check($sformatf("single_wr_e%0d", k), disp_cmd_wr, exp_wr[k]);
            check($sformatf("single_rd_e%0d", k), cmdreg_rd, exp_rd[k]);
            check($sformatf("single_out_e%0d", k), disp_cmd_out, 8'hA5);
        end
`ifdef CMD_FIFO_WRITER_COUNT_EN
        check("single_count", wr_count, 16'd1);
`endif

        // Full stall for 20 cycles, then release
        nff = 1'b0;
        cmdreg_data = 8'h3C;
        cmdreg_data_avail = 1'b1;
        rd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmdreg_rd === 1'b1) rd_cnt++;
            if (disp_cmd_wr !== 1'b1) rd_cnt += 100;
        end
        check("stall_no_activity", rd_cnt, 0);
        nff = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        check("stall_release_accept", cmdreg_rd, 1'b1);
        cmdreg_data_avail = 1'b0;
        repeat (8) @(negedge clk);

        // Full asserted during the pulse does not abort the write
        cmdreg_data = 8'hC3;
        cmdreg_data_avail = 1'b1;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        check("fullpulse_accept", cmdreg_rd, 1'b1);
        cmdreg_data_avail = 1'b0;
        @(negedge clk);
        nff = 1'b0;
        cmdreg_data = 8'h77;
        cmdreg_data_avail = 1'b1;
        repeat (3) @(negedge clk);
        check("fullpulse_wr_rises_e4", disp_cmd_wr, 1'b1);
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmdreg_rd === 1'b1) rd_cnt++;
        end
        check("fullpulse_no_accept", rd_cnt, 0);
        nff = 1'b1;
        exp_q.push_back(8'h77);
        wait_rd("fullpulse_resume", n);
        check("fullpulse_resume_latency", n, 1);
        cmdreg_data_avail = 1'b0;
        repeat (8) @(negedge clk);

        // Back-to-back: 01 then 02, accepts 6 cycles apart
        cmdreg_data = 8'h01;
        cmdreg_data_avail = 1'b1;
        exp_q.push_back(8'h01);
        wait_rd("b2b_first", n);
        cmdreg_data = 8'h02;
        exp_q.push_back(8'h02);
        wait_rd("b2b_second", n);
        check("b2b_spacing", n, 6);
        cmdreg_data_avail = 1'b0;
        repeat (8) @(negedge clk);

        // Async reset half a cycle after E2; byte E7 is lost
        cmdreg_data = 8'hE7;
        cmdreg_data_avail = 1'b1;
        @(negedge clk);
        check("rstmid_accept", cmdreg_rd, 1'b1);
        cmdreg_data_avail = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_wr_low_before", disp_cmd_wr, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid_wr", disp_cmd_wr, 1'b1);
        check("rstmid_rd", cmdreg_rd, 1'b0);
        check("rstmid_out", disp_cmd_out, 8'h00);
`ifdef CMD_FIFO_WRITER_COUNT_EN
        check("rstmid_count", wr_count, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Recovered to idle: next byte accepted on the first edge
        cmdreg_data = 8'h81;
        cmdreg_data_avail = 1'b1;
        exp_q.push_back(8'h81);
        @(negedge clk);
        check("post_rst_accept", cmdreg_rd, 1'b1);
        cmdreg_data_avail = 1'b0;
        repeat (10) @(negedge clk);
`ifdef CMD_FIFO_WRITER_COUNT_EN
        check("post_rst_count", wr_count, 16'd1);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        check("fifo_write_total", captured, 7);
        check("consume_total", rd_seen, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
